// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: state codes, opcodes,
// functs, mux-select encodings and the packed control word.
package mips_ctrl_pkg;

   localparam int ST_W = 4;

   localparam logic [ST_W-1:0] S_FETCH     = 4'd0;
   localparam logic [ST_W-1:0] S_DECODE    = 4'd1;
   localparam logic [ST_W-1:0] S_MEM_ADDR  = 4'd2;
   localparam logic [ST_W-1:0] S_MEM_RD    = 4'd3;
   localparam logic [ST_W-1:0] S_MEM_WB    = 4'd4;
   localparam logic [ST_W-1:0] S_MEM_WR    = 4'd5;
   localparam logic [ST_W-1:0] S_R_EXEC    = 4'd6;
   localparam logic [ST_W-1:0] S_R_WB      = 4'd7;
   localparam logic [ST_W-1:0] S_ADDI_EXEC = 4'd8;
   localparam logic [ST_W-1:0] S_ADDI_WB   = 4'd9;
   localparam logic [ST_W-1:0] S_BRANCH    = 4'd10;
   localparam logic [ST_W-1:0] S_JUMP      = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
   } ctrl_t;

   function automatic logic funct_legal(input logic [5:0] fn);
      return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
             (fn == FN_OR)  || (fn == FN_SLT);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath bundle. master = datapath/IR side, slave = controller.
// Handshake is mem_ready only: strobes stay up until the memory reports completion.
interface mips_multicycle_ctrl_if #(
   parameter int STATE_W = 4,
   parameter int CNT_W   = 32
);
   logic [5:0]         opcode;
   logic [5:0]         func;
   logic               zero;
   logic               mem_ready;
   logic               pc_write;
   logic               pc_write_cond;
   logic               i_or_d;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               reg_dst;
   logic               mem_to_reg;
   logic               reg_write;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         alu_op;
   logic [1:0]         pc_source;
   logic               illegal_op;
   logic [STATE_W-1:0] state;
   logic [CNT_W-1:0]   retired;

   modport master (
      output opcode, func, zero, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state, retired
   );

   modport slave (
      input  opcode, func, zero, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_source, illegal_op, state, retired
   );
endinterface

// File: rtl/mips_ctrl_decode.sv
// Combinational state -> control-word decode, zero latency.
// FETCH loads of IR/PC wait on mem_ready; i_en low forces the whole word to 0.
module mips_ctrl_decode
   import mips_ctrl_pkg::*;
#(
   parameter int STATE_W = ST_W
)(
   input  logic [STATE_W-1:0] i_state,
   input  logic               i_mem_ready,
   input  logic               i_en,
   output ctrl_t              o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      if (i_en) begin
         case (i_state)
            S_FETCH: begin
               o_ctrl.mem_read  = 1'b1;
               o_ctrl.ir_write  = i_mem_ready;
               o_ctrl.pc_write  = i_mem_ready;
               o_ctrl.alu_src_b = SRCB_FOUR;
               o_ctrl.alu_op    = ALU_ADD;
               o_ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
               o_ctrl.alu_src_b = SRCB_IMM_SH;
               o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
               o_ctrl.alu_src_a = 1'b1;
               o_ctrl.alu_src_b = SRCB_IMM;
               o_ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
               o_ctrl.mem_read = 1'b1;
               o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
               o_ctrl.reg_write  = 1'b1;
               o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
               o_ctrl.mem_write = 1'b1;
               o_ctrl.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
               o_ctrl.alu_src_a = 1'b1;
               o_ctrl.alu_src_b = SRCB_RT;
               o_ctrl.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
               o_ctrl.reg_write = 1'b1;
               o_ctrl.reg_dst   = 1'b1;
            end
            S_ADDI_WB: o_ctrl.reg_write = 1'b1;
            // beq: ALU subtracts for the zero flag while PC takes ALUOut (the target).
            S_BRANCH: begin
               o_ctrl.alu_src_a     = 1'b1;
               o_ctrl.alu_src_b     = SRCB_RT;
               o_ctrl.alu_op        = ALU_SUB;
               o_ctrl.pc_write_cond = 1'b1;
               o_ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
               o_ctrl.pc_write  = 1'b1;
               o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
         endcase
      end
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: lw 5 cycles, sw/R/addi 4, beq/j 3 with zero-wait memory.
// FETCH, MEM_RD and MEM_WR hold (strobe up) until mem_ready; retired saturates.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int STATE_W = ST_W
)(
   input  logic                 clk,
   input  logic                 rst,
   mips_multicycle_ctrl_if.slave bus
);

   logic [STATE_W-1:0] r_state;
   logic [CNT_W-1:0]   r_retired;
   logic               r_illegal;
   logic [STATE_W-1:0] w_next_state;
   logic               w_illegal_dec;
   logic               w_retire;
   ctrl_t              w_ctrl;
   logic               w_unused;

   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_FETCH;
      else      r_state <= w_next_state;
   end

   always_comb begin
      w_next_state  = S_FETCH;
      w_illegal_dec = 1'b0;
      w_retire      = 1'b0;
      case (r_state)
         S_FETCH:  w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (bus.opcode)
               OP_RTYPE: begin
                  if (funct_legal(bus.func)) w_next_state  = S_R_EXEC;
                  else                       w_illegal_dec = 1'b1;
               end
               OP_LW, OP_SW: w_next_state  = S_MEM_ADDR;
               OP_BEQ:       w_next_state  = S_BRANCH;
               OP_ADDI:      w_next_state  = S_ADDI_EXEC;
               OP_J:         w_next_state  = S_JUMP;
               default:      w_illegal_dec = 1'b1;
            endcase
         end
         S_MEM_ADDR:  w_next_state = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:    w_next_state = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
         S_MEM_WR: begin
            w_next_state = bus.mem_ready ? S_FETCH : S_MEM_WR;
            w_retire     = bus.mem_ready;
         end
         S_R_EXEC:    w_next_state = S_R_WB;
         S_ADDI_EXEC: w_next_state = S_ADDI_WB;
         S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
         default:     w_next_state = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_retired <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= w_illegal_dec;
         if (w_retire && !(&r_retired)) r_retired <= r_retired + 1'b1;
      end
   end

   mips_ctrl_decode #(.STATE_W(STATE_W)) u_decode (
      .i_state     (r_state),
      .i_mem_ready (bus.mem_ready),
      .i_en        (rst),
      .o_ctrl      (w_ctrl)
   );

   assign bus.pc_write      = w_ctrl.pc_write;
   assign bus.pc_write_cond = w_ctrl.pc_write_cond;
   assign bus.i_or_d        = w_ctrl.i_or_d;
   assign bus.mem_read      = w_ctrl.mem_read;
   assign bus.mem_write     = w_ctrl.mem_write;
   assign bus.ir_write      = w_ctrl.ir_write;
   assign bus.reg_dst       = w_ctrl.reg_dst;
   assign bus.mem_to_reg    = w_ctrl.mem_to_reg;
   assign bus.reg_write     = w_ctrl.reg_write;
   assign bus.alu_src_a     = w_ctrl.alu_src_a;
   assign bus.alu_src_b     = w_ctrl.alu_src_b;
   assign bus.alu_op        = w_ctrl.alu_op;
   assign bus.pc_source     = w_ctrl.pc_source;
   assign bus.illegal_op    = r_illegal & rst;
   assign bus.state         = r_state;
   assign bus.retired       = r_retired;

   // zero qualifies pc_write_cond in the datapath, not here.
   assign w_unused = bus.zero;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: opcode table, hand-written reset/wait-state
// sequences, then random instructions against a per-instruction phase-list model.
module tb_mips_multicycle_ctrl;
   import mips_ctrl_pkg::*;

   localparam int TB_CNT_W = 4;
   localparam int MAXRET   = (1 << TB_CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   mips_multicycle_ctrl_if #(.STATE_W(ST_W), .CNT_W(TB_CNT_W)) bus ();

   mips_multicycle_ctrl #(.CNT_W(TB_CNT_W), .STATE_W(ST_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;
   int m_ret = 0;
   bit pend_ill = 1'b0;

   logic [15:0] act_ctl;
   assign act_ctl = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                     bus.mem_write, bus.ir_write, bus.reg_dst, bus.mem_to_reg,
                     bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                     bus.pc_source};

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_word(input logic [3:0] ph, input logic mr);
      logic pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca;
      logic [1:0] srcb, aop, pcs;
      {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca} = '0;
      srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (ph)
         S_FETCH:     begin mrd = 1'b1; irw = mr; pcw = mr; srcb = 2'b01; end
         S_DECODE:    srcb = 2'b11;
         S_MEM_ADDR:  begin srca = 1'b1; srcb = 2'b10; end
         S_MEM_RD:    begin mrd = 1'b1; iord = 1'b1; end
         S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
         S_MEM_WR:    begin mwr = 1'b1; iord = 1'b1; end
         S_R_EXEC:    begin srca = 1'b1; aop = 2'b10; end
         S_R_WB:      begin rw = 1'b1; rdst = 1'b1; end
         S_ADDI_EXEC: begin srca = 1'b1; srcb = 2'b10; end
         S_ADDI_WB:   rw = 1'b1;
         S_BRANCH:    begin srca = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
         S_JUMP:      begin pcw = 1'b1; pcs = 2'b10; end
         default:     ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs};
   endfunction

   // One instruction from FETCH back to FETCH; the expected phase list comes from the ISA.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                            input int waits, input bit rnd,
                            output int cycles, output int n_mwr, output int n_rw);
      logic [3:0] seq[$];
      bit   legal, held, mem_ph;
      logic mr;
      int   w;
      bus.opcode = op;
      bus.func   = fn;
      bus.zero   = zr;
      seq   = {S_FETCH, S_DECODE};
      legal = 1'b1;
      case (op)
         6'h23: seq = {seq, S_MEM_ADDR, S_MEM_RD, S_MEM_WB};
         6'h2B: seq = {seq, S_MEM_ADDR, S_MEM_WR};
         6'h04: seq = {seq, S_BRANCH};
         6'h08: seq = {seq, S_ADDI_EXEC, S_ADDI_WB};
         6'h02: seq = {seq, S_JUMP};
         6'h00: begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)
               seq = {seq, S_R_EXEC, S_R_WB};
            else
               legal = 1'b0;
         end
         default: legal = 1'b0;
      endcase
      cycles = 0; n_mwr = 0; n_rw = 0;
      foreach (seq[k]) begin
         w = 0;
         do begin
            mem_ph = (seq[k] == S_FETCH) || (seq[k] == S_MEM_RD) || (seq[k] == S_MEM_WR);
            if (rnd) mr = ($urandom_range(0, 2) != 0) || (w >= 3);
            else     mr = !((seq[k] == S_MEM_RD) || (seq[k] == S_MEM_WR)) || (w >= waits);
            bus.mem_ready = mr;
            @(negedge clk);
            chk("state", bus.state, seq[k]);
            chk($sformatf("ctl_s%0d", seq[k]), act_ctl, exp_word(seq[k], mr));
            chk("illegal_op", bus.illegal_op, (k == 0 && w == 0) ? pend_ill : 1'b0);
            chk("retired", bus.retired, m_ret);
            cycles++;
            n_mwr += bus.mem_write;
            n_rw  += bus.reg_write;
            held = mem_ph && !mr;
            tick();
            w++;
         end while (held);
      end
      pend_ill = !legal;
      if (legal && m_ret != MAXRET) m_ret++;
   endtask

   typedef struct {
      logic [5:0] op;
      logic [5:0] fn;
      int         cyc;
      bit         ret;
      bit         ill;
   } vec_t;

   vec_t tbl[10];
   logic [5:0] legal_fn[5];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, nmw, nrw, r0;
      logic [5:0] op, fn;

      tbl[0] = '{6'h23, 6'h00, 5, 1'b1, 1'b0};
      tbl[1] = '{6'h2B, 6'h00, 4, 1'b1, 1'b0};
      tbl[2] = '{6'h00, 6'h20, 4, 1'b1, 1'b0};
      tbl[3] = '{6'h00, 6'h2A, 4, 1'b1, 1'b0};
      tbl[4] = '{6'h00, 6'h21, 2, 1'b0, 1'b1};
      tbl[5] = '{6'h08, 6'h3F, 4, 1'b1, 1'b0};
      tbl[6] = '{6'h04, 6'h00, 3, 1'b1, 1'b0};
      tbl[7] = '{6'h02, 6'h00, 3, 1'b1, 1'b0};
      tbl[8] = '{6'h3F, 6'h20, 2, 1'b0, 1'b1};
      tbl[9] = '{6'h01, 6'h00, 2, 1'b0, 1'b1};
      legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

      bus.opcode = 6'h00; bus.func = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_state", bus.state, S_FETCH);
      chk("rst_ctl", act_ctl, 16'h0);
      chk("rst_illegal", bus.illegal_op, 1'b0);
      chk("rst_retired", bus.retired, 0);
      rst = 1'b1;
      tick();

      foreach (tbl[i]) begin
         r0 = m_ret;
         run_instr(tbl[i].op, tbl[i].fn, 1'b0, 0, 1'b0, cyc, nmw, nrw);
         chk($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
         chk($sformatf("tbl%0d_retired", i), bus.retired, (r0 + tbl[i].ret > MAXRET) ? MAXRET : r0 + tbl[i].ret);
         chk($sformatf("tbl%0d_illegal", i), bus.illegal_op, tbl[i].ill);
      end

      // Reset held for three edges while in JUMP.
      bus.opcode = 6'h02; bus.mem_ready = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("jrst_in_jump", bus.state, S_JUMP);
      rst = 1'b0;
      #1;
      chk("jrst_ctl_override", act_ctl, 16'h0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("jrst_state", bus.state, S_FETCH);
         chk("jrst_ctl", act_ctl, 16'h0);
         chk("jrst_retired", bus.retired, 0);
      end
      m_ret = 0; pend_ill = 1'b0;
      rst = 1'b1; bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("jrst_release_mem_read", bus.mem_read, 1'b1);
      chk("jrst_release_ctl", act_ctl, exp_word(S_FETCH, 1'b0));
      tick();

      // sw with three wait states in MEM_WR.
      r0 = m_ret;
      run_instr(6'h2B, 6'h00, 1'b0, 3, 1'b0, cyc, nmw, nrw);
      chk("sw_wait_mem_write_cycles", nmw, 4);
      chk("sw_wait_reg_write", nrw, 0);
      chk("sw_wait_cycles", cyc, 7);
      chk("sw_wait_retired", bus.retired, r0 + 1);

      r0 = m_ret;
      run_instr(6'h23, 6'h00, 1'b0, 2, 1'b0, cyc, nmw, nrw);
      chk("lw_wait_cycles", cyc, 7);
      chk("lw_wait_reg_write", nrw, 1);
      chk("lw_wait_retired", bus.retired, r0 + 1);

      run_instr(6'h04, 6'h00, 1'b1, 0, 1'b0, cyc, nmw, nrw);
      chk("beq_z1_cycles", cyc, 3);
      run_instr(6'h04, 6'h00, 1'b0, 0, 1'b0, cyc, nmw, nrw);
      chk("beq_z0_cycles", cyc, 3);

      // Reset during a stalled store must kill the strobe at once.
      bus.opcode = 6'h2B; bus.mem_ready = 1'b1;
      tick();
      tick();
      tick();
      bus.mem_ready = 1'b0;
      @(negedge clk);
      chk("wrst_in_mem_wr", bus.state, S_MEM_WR);
      chk("wrst_mem_write_before", bus.mem_write, 1'b1);
      rst = 1'b0;
      #1;
      chk("wrst_mem_write_gated", bus.mem_write, 1'b0);
      tick();
      chk("wrst_state", bus.state, S_FETCH);
      chk("wrst_retired", bus.retired, 0);
      @(negedge clk);
      chk("wrst_ctl", act_ctl, 16'h0);
      m_ret = 0; pend_ill = 1'b0;
      rst = 1'b1;
      tick();

      for (int n = 0; n < 150; n++) begin
         case ($urandom_range(0, 7))
            0: op = 6'h00;
            1: op = 6'h23;
            2: op = 6'h2B;
            3: op = 6'h04;
            4: op = 6'h08;
            5: op = 6'h02;
            default: op = 6'($urandom);
         endcase
         if ($urandom_range(0, 3) == 0) fn = 6'($urandom);
         else fn = legal_fn[$urandom_range(0, 4)];
         run_instr(op, fn, 1'($urandom_range(0, 1)), 0, 1'b1, cyc, nmw, nrw);
         chk("rand_strobes_exclusive", bus.mem_read & bus.mem_write, 1'b0);
      end
      @(negedge clk);
      chk("rand_final_retired", bus.retired, m_ret);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
